// File: rtl/accum_decimator.sv
// Integrate-and-dump decimator: sums N signed samples into a 2-entry output FIFO.
// Optional drop monitor (overflow, drop_count) built when ACCUM_DECIMATOR_DROP_MONITOR_EN is defined.
module accum_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int RATE_WIDTH = 16,
    localparam int OUT_WIDTH = DATA_WIDTH + RATE_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                        din_valid,
    input  logic        [RATE_WIDTH-1:0] rate,
    output logic signed [OUT_WIDTH-1:0]  dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        overflow,
    input  logic                        clear_overflow,
    output logic        [15:0]           drop_count
);

    logic        [RATE_WIDTH-1:0] cnt_q, cnt_d;
    logic        [RATE_WIDTH-1:0] n_q, n_d;
    logic        [RATE_WIDTH-1:0] n_cur;
    logic signed [OUT_WIDTH-1:0]  acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0]  din_ext;
    logic signed [OUT_WIDTH-1:0]  result;
    logic                         last;
    logic                         push;
    logic                         pop;
    logic                         drop;
    logic signed [OUT_WIDTH-1:0]  mem0_q, mem0_d;
    logic signed [OUT_WIDTH-1:0]  mem1_q, mem1_d;
    logic        [1:0]            count_q, count_d;

    // The block length is taken from rate on the first sample, so the current block uses n_cur.
    always_comb begin
        din_ext = {{RATE_WIDTH{din[DATA_WIDTH-1]}}, din};
        if (cnt_q == '0) begin
            n_cur = (rate <= RATE_WIDTH'(1)) ? RATE_WIDTH'(1) : rate;
        end else begin
            n_cur = n_q;
        end
        last   = (cnt_q == (n_cur - RATE_WIDTH'(1)));
        result = (cnt_q == '0) ? din_ext : (acc_q + din_ext);
        push   = din_valid && last;

        cnt_d = cnt_q;
        n_d   = n_q;
        acc_d = acc_q;
        if (din_valid) begin
            n_d   = n_cur;
            acc_d = result;
            cnt_d = last ? '0 : (cnt_q + RATE_WIDTH'(1));
        end
    end

    // Pop first, then the push lands in the slot the remaining occupancy points at.
    always_comb begin
        pop     = (count_q != 2'd0) && dout_ready;
        drop    = push && !pop && (count_q == 2'd2);
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        count_d = count_q;
        if (pop) begin
            mem0_d  = mem1_q;
            count_d = count_q - 2'd1;
        end
        if (push && !drop) begin
            if (count_d == 2'd0) begin
                mem0_d = result;
            end else begin
                mem1_d = result;
            end
            count_d = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            n_q     <= RATE_WIDTH'(1);
            acc_q   <= '0;
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            count_q <= count_d;
        end
    end

    assign dout       = mem0_q;
    assign dout_valid = (count_q != 2'd0);

`ifdef ACCUM_DECIMATOR_DROP_MONITOR_EN
    logic        overflow_q, overflow_d;
    logic [15:0] drop_count_q, drop_count_d;

    // A drop in the same cycle as a clear survives the clear.
    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (clear_overflow) begin
            overflow_d   = drop;
            drop_count_d = drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q   <= 1'b0;
            drop_count_q <= 16'd0;
        end else begin
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
`else
    logic unused_monitor;
    assign unused_monitor = clear_overflow ^ drop;
    assign overflow       = 1'b0;
    assign drop_count     = 16'd0;
`endif

endmodule

// File: tb/tb_accum_decimator.sv
// Scoreboard bench for accum_decimator; honours ACCUM_DECIMATOR_DROP_MONITOR_EN like the design.
module tb_accum_decimator;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] din = '0;
    logic               din_valid = 1'b0;
    logic        [15:0] rate = '0;
    logic signed [31:0] dout;
    logic               dout_valid;
    logic               dout_ready = 1'b0;
    logic               overflow;
    logic               clear_overflow = 1'b0;
    logic        [15:0] drop_count;

    int testCount = 0;
    int failCount = 0;

    longint expQ[$];
    longint mCnt = 0;
    longint mN = 1;
    longint mAcc = 0;
    logic   mOvf = 1'b0;
    longint mDrops = 0;

    accum_decimator #(.DATA_WIDTH(16), .RATE_WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(din_valid),
        .rate(rate),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .overflow(overflow),
        .clear_overflow(clear_overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        testCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    // Checks outputs from the previous edge, then drives one cycle and advances the reference model.
    task automatic applyStimulus(input logic v, input longint d, input longint r,
                                 input logic rdy, input logic clr);
        logic   doPop;
        logic   doPush;
        logic   doDrop;
        longint res;
        din_valid      = v;
        din            = d[15:0];
        rate           = r[15:0];
        dout_ready     = rdy;
        clear_overflow = clr;

        checkOutput("dout_valid", longint'(dout_valid), longint'(expQ.size() != 0));
        if (expQ.size() != 0) checkOutput("dout", longint'(dout), expQ[0]);
        checkOutput("overflow", longint'(overflow), longint'(mOvf));
        checkOutput("drop_count", longint'(drop_count), mDrops);

        doPush = 1'b0;
        res    = 0;
        if (v) begin
            if (mCnt == 0) begin
                mN   = (r <= 1) ? 1 : r;
                mAcc = d;
            end else begin
                mAcc = mAcc + d;
            end
            mCnt++;
            if (mCnt == mN) begin
                doPush = 1'b1;
                res    = mAcc;
                mCnt   = 0;
            end
        end
        doPop  = (expQ.size() != 0) && rdy;
        doDrop = doPush && !doPop && (expQ.size() == 2);
        if (doPop) void'(expQ.pop_front());
        if (doPush && !doDrop) expQ.push_back(res);
`ifdef ACCUM_DECIMATOR_DROP_MONITOR_EN
        if (clr) begin
            mOvf   = doDrop;
            mDrops = doDrop ? 1 : 0;
        end else if (doDrop) begin
            mOvf = 1'b1;
            if (mDrops != 65535) mDrops++;
        end
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset is asserted alongside active inputs to exercise its priority.
    task automatic doReset();
        rst            = 1'b1;
        din_valid      = 1'b1;
        din            = 16'sd77;
        rate           = 16'd1;
        dout_ready     = 1'b1;
        clear_overflow = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        mCnt   = 0;
        mN     = 1;
        mAcc   = 0;
        mOvf   = 1'b0;
        mDrops = 0;
        checkOutput("rst_dout_valid", longint'(dout_valid), 0);
        checkOutput("rst_dout", longint'(dout), 0);
        checkOutput("rst_overflow", longint'(overflow), 0);
        checkOutput("rst_drop_count", longint'(drop_count), 0);
    endtask

    task automatic idle(input int cycles, input logic rdy);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 0, 1, rdy, 1'b0);
    endtask

    initial begin
        longint blk[4];
        @(negedge clk);
        doReset();

        // Basic block of four with a free downstream.
        blk = '{1000, -200, 300, -100};
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, blk[i], 4, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Rate 0 and 1 both pass samples straight through.
        applyStimulus(1'b1, -32768, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, -32768, 1, 1'b1, 1'b0);
        applyStimulus(1'b1, -32768, 1, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Fill the FIFO with a stalled downstream and force a drop, then clear and drain.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32767, 2, 1'b0, 1'b0);
        idle(3, 1'b0);
        applyStimulus(1'b0, 0, 2, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Full FIFO with a pop on the push cycle keeps every result.
        applyStimulus(1'b1, 11, 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 22, 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 33, 1, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Drop coincident with clear leaves one recorded drop.
        applyStimulus(1'b1, 5, 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 6, 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 7, 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8, 1, 1'b0, 1'b1);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Partial block discarded by reset.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 10, 8, 1'b1, 1'b0);
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 10, 8, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Rate change mid-block only affects the following blocks.
        applyStimulus(1'b1, 1, 3, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1, 5, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Random gaps, backpressure, rates and data.
        for (int i = 0; i < 400; i++) begin
            longint rr;
            longint dd;
            rr = longint'($urandom_range(0, 4));
            dd = longint'($urandom_range(0, 65535)) - 32768;
            applyStimulus(1'($urandom_range(0, 3) != 0), dd, rr,
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        idle(6, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
